// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receiver control (frame FSM, config shadow, RX FIFO).
// Define UART_RX_CTRL_DROP_CNT_EN to enable the timed-out frame counter drop_cnt.
module uart_rx_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter logic [4:0] PRESCALE_RST = 5'd8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             RX_IN,
  input  logic [WIDTH-1:0] P_DATA,
  input  logic             Data_Valid,
  input  logic             cfg_wr,
  input  logic [4:0]       cfg_prescale,
  input  logic             cfg_par_en,
  input  logic             cfg_par_typ,
  output logic [4:0]       prescale,
  output logic             PAR_EN,
  output logic             PAR_TYP,
  output logic             cfg_pending,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             overflow,
  input  logic             ovf_clr,
  output logic [7:0]       drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, RECV} state_t;
  state_t state, state_nx;
  logic rx_q;
  logic [8:0] cnt;
  logic [4:0] sh_pre;
  logic sh_pen, sh_pty;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] occ;
  logic fall, term, apply, pop, push, full, ovf_evt;
  always_comb begin
    fall = rx_q & ~RX_IN;
    term = cnt == 9'(12 * prescale - 1);
    state_nx = state == IDLE ? (fall ? RECV : IDLE) : (Data_Valid | term ? IDLE : RECV);
    apply = state == IDLE & cfg_pending & RX_IN & ~fall;
    full = occ[AW];
    pop = rd_valid & rd_ready;
    push = Data_Valid & (~full | pop);
    ovf_evt = Data_Valid & full & ~pop;
  end
  assign rd_valid = occ != '0;
  assign rd_data = rd_valid ? mem[rp] : '0;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      rx_q <= 1'b1;
      cnt <= '0;
      wp <= '0;
      rp <= '0;
      occ <= '0;
      overflow <= 1'b0;
      cfg_pending <= 1'b0;
      prescale <= PRESCALE_RST;
      PAR_EN <= 1'b1;
      PAR_TYP <= 1'b0;
      sh_pre <= PRESCALE_RST;
      sh_pen <= 1'b1;
      sh_pty <= 1'b0;
    end else begin
      state <= state_nx;
      rx_q <= RX_IN;
      cnt <= state == RECV ? cnt + 9'd1 : 9'd0;
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      occ <= occ + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      overflow <= ovf_evt | (overflow & ~ovf_clr);
      // a fresh write wins over apply so the newest request is the one applied
      if (cfg_wr) begin
        sh_pre <= cfg_prescale;
        sh_pen <= cfg_par_en;
        sh_pty <= cfg_par_typ;
        cfg_pending <= 1'b1;
      end else if (apply) begin
        prescale <= sh_pre;
        PAR_EN <= sh_pen;
        PAR_TYP <= sh_pty;
        cfg_pending <= 1'b0;
      end
    end
  end
  always_ff @(posedge CLK)
    if (push & ~RST) mem[wp] <= P_DATA;
`ifdef UART_RX_CTRL_DROP_CNT_EN
  logic timeout;
  assign timeout = state == RECV & ~Data_Valid & term;
  always_ff @(posedge CLK)
    if (RST) drop_cnt <= '0;
    else if (timeout && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
`else
  assign drop_cnt = '0;
`endif
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed and randomized checks of uart_rx_ctrl against a queue-based model.
module tb_uart_rx_ctrl;
  localparam int DEPTH = 4;
`ifdef UART_RX_CTRL_DROP_CNT_EN
  localparam int DROP_EN = 1;
`else
  localparam int DROP_EN = 0;
`endif
  logic CLK = 0, RST = 0, RX_IN = 1, Data_Valid = 0, cfg_wr = 0;
  logic cfg_par_en = 0, cfg_par_typ = 0, rd_ready = 0, ovf_clr = 0;
  logic [7:0] P_DATA = 0;
  logic [4:0] cfg_prescale = 0;
  logic [4:0] prescale;
  logic PAR_EN, PAR_TYP, cfg_pending, rd_valid, overflow;
  logic [7:0] rd_data, drop_cnt;
  int passed = 0, total = 0;
  bit cmp_en = 0;
  bit m_rxq, m_busy, m_ovf, m_pend, m_pen, m_pty, s_pen, s_pty;
  int m_pre, s_pre, m_drop, cyc = 0, dl = 0;
  logic [7:0] q[$];
  logic [7:0] e42[4] = '{8'h11, 8'h12, 8'h13, 8'h7E};

  always #5 CLK = ~CLK;

  uart_rx_ctrl dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .cfg_wr(cfg_wr), .cfg_prescale(cfg_prescale), .cfg_par_en(cfg_par_en), .cfg_par_typ(cfg_par_typ),
    .prescale(prescale), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .cfg_pending(cfg_pending),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .overflow(overflow), .ovf_clr(ovf_clr), .drop_cnt(drop_cnt)
  );

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // frame lifetime is tracked as an absolute deadline rather than a running counter
  task automatic model_step();
    bit fall, pop, full, apply;
    cyc++;
    if (RST) begin
      m_rxq = 1; m_busy = 0; q.delete(); m_ovf = 0; m_drop = 0; m_pend = 0;
      m_pre = 8; m_pen = 1; m_pty = 0; s_pre = 8; s_pen = 1; s_pty = 0;
      return;
    end
    fall = m_rxq && !RX_IN;
    apply = !m_busy && m_pend && RX_IN && !fall;
    pop = q.size() > 0 && rd_ready;
    full = q.size() == DEPTH;
    if (Data_Valid && full && !pop) m_ovf = 1;
    else if (ovf_clr) m_ovf = 0;
    if (pop) void'(q.pop_front());
    if (Data_Valid && (!full || pop)) q.push_back(P_DATA);
    if (!m_busy) begin
      if (fall) begin m_busy = 1; dl = cyc + 12 * m_pre; end
    end else if (Data_Valid) m_busy = 0;
    else if (cyc == dl) begin
      m_busy = 0;
      if (DROP_EN == 1 && m_drop < 255) m_drop++;
    end
    if (cfg_wr) begin
      s_pre = cfg_prescale; s_pen = cfg_par_en; s_pty = cfg_par_typ; m_pend = 1;
    end else if (apply) begin
      m_pre = s_pre; m_pen = s_pen; m_pty = s_pty; m_pend = 0;
    end
    m_rxq = RX_IN;
  endtask

  always @(negedge CLK) if (cmp_en) begin
    cmp("prescale", prescale, m_pre);
    cmp("PAR_EN", PAR_EN, m_pen);
    cmp("PAR_TYP", PAR_TYP, m_pty);
    cmp("cfg_pending", cfg_pending, m_pend);
    cmp("rd_valid", rd_valid, q.size() != 0);
    cmp("rd_data", rd_data, q.size() != 0 ? q[0] : 8'h00);
    cmp("overflow", overflow, m_ovf);
    cmp("drop_cnt", drop_cnt, m_drop);
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge CLK);
      model_step();
      #1;
    end
  endtask

  task automatic dv(logic [7:0] b);
    Data_Valid = 1; P_DATA = b;
    tick();
    Data_Valid = 0;
  endtask

  task automatic check_reset(string tag);
    cmp({tag, "_prescale"}, prescale, 8);
    cmp({tag, "_par_en"}, PAR_EN, 1);
    cmp({tag, "_par_typ"}, PAR_TYP, 0);
    cmp({tag, "_pending"}, cfg_pending, 0);
    cmp({tag, "_rd_valid"}, rd_valid, 0);
    cmp({tag, "_rd_data"}, rd_data, 0);
    cmp({tag, "_overflow"}, overflow, 0);
    cmp({tag, "_drop"}, drop_cnt, 0);
  endtask

  initial begin
    RST = 1;
    tick(2);
    RST = 0;
    cmp_en = 1;
    check_reset("rst");
    // single frame ended by Data_Valid
    RX_IN = 0;
    tick(49);
    dv(8'hA5);
    cmp("t38_valid", rd_valid, 1);
    cmp("t38_data", rd_data, 8'hA5);
    RX_IN = 1;
    tick();
    rd_ready = 1; tick(); rd_ready = 0;
    cmp("t38_empty", rd_valid, 0);
    // config written mid-frame waits for an idle, high line
    RX_IN = 0;
    tick(4);
    cfg_wr = 1; cfg_prescale = 16; cfg_par_en = 0; cfg_par_typ = 0;
    tick();
    cfg_wr = 0;
    cmp("t39_pending", cfg_pending, 1);
    cmp("t39_hold", prescale, 8);
    tick(10);
    cmp("t39_hold2", prescale, 8);
    dv(8'h3C);
    tick(2);
    cmp("t39_low_hold", prescale, 8);
    cmp("t39_low_pending", cfg_pending, 1);
    RX_IN = 1;
    tick();
    cmp("t39_applied", prescale, 16);
    cmp("t39_par_en", PAR_EN, 0);
    cmp("t39_cleared", cfg_pending, 0);
    rd_ready = 1; tick(); rd_ready = 0;
    cfg_prescale = 8; cfg_par_en = 1; cfg_wr = 1;
    tick();
    cfg_wr = 0;
    tick();
    cmp("t39_restore", prescale, 8);
    // overflow on fifth word
    for (int i = 1; i <= 5; i++) dv(8'(i));
    cmp("t40_ovf", overflow, 1);
    for (int i = 1; i <= 4; i++) begin
      cmp("t40_pop", rd_data, i);
      rd_ready = 1; tick(); rd_ready = 0;
    end
    cmp("t40_empty", rd_valid, 0);
    ovf_clr = 1; tick(); ovf_clr = 0;
    cmp("t40_clr", overflow, 0);
    // timeout, then a held-low line
    RX_IN = 0;
    tick(96);
    cmp("t41_before", drop_cnt, 0);
    tick();
    cmp("t41_drop", drop_cnt, DROP_EN);
    tick(200);
    cmp("t41_held_low", drop_cnt, DROP_EN);
    RX_IN = 1;
    tick();
    // push and pop together while full
    for (int i = 0; i < 4; i++) dv(8'h10 + 8'(i));
    Data_Valid = 1; P_DATA = 8'h7E; rd_ready = 1;
    tick();
    Data_Valid = 0; rd_ready = 0;
    cmp("t42_no_ovf", overflow, 0);
    dv(8'hEE);
    cmp("t42_still_full", overflow, 1);
    for (int i = 0; i < 4; i++) begin
      cmp("t42_pop", rd_data, e42[i]);
      rd_ready = 1; tick(); rd_ready = 0;
    end
    cmp("t42_empty", rd_valid, 0);
    ovf_clr = 1; tick(); ovf_clr = 0;
    // reset mid-frame with queued words and pending config
    dv(8'h55);
    dv(8'h66);
    cfg_prescale = 3; cfg_wr = 1;
    tick();
    cfg_wr = 0; RX_IN = 0;
    tick(5);
    RST = 1; RX_IN = 1;
    tick();
    RST = 0;
    check_reset("t43");
    for (int i = 0; i < 4000; i++) begin
      RST = $urandom_range(0, 499) == 0;
      if ($urandom_range(0, 9) == 0) RX_IN = ~RX_IN;
      Data_Valid = $urandom_range(0, 19) == 0;
      P_DATA = 8'($urandom);
      rd_ready = $urandom_range(0, 2) == 0;
      cfg_wr = $urandom_range(0, 29) == 0;
      cfg_prescale = 5'($urandom_range(1, 3));
      cfg_par_en = 1'($urandom);
      cfg_par_typ = 1'($urandom);
      ovf_clr = $urandom_range(0, 19) == 0;
      tick();
    end
    cmp_en = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
